// File: rtl/grayscale_pkg.sv
`default_nettype none
// ============================================================================
// Package  : grayscale_pkg
// Purpose  : Shared FSM encoding and fixed-point constants for the RGB to
//            gray frame converter.
// Revision : 1.0 - initial release
// ============================================================================
package grayscale_pkg;

  // Frame controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Luma weights, scaled so that they sum to 16 (5 + 9 + 2)
  localparam int unsigned COEF_R = 5;
  localparam int unsigned COEF_G = 9;
  localparam int unsigned COEF_B = 2;

  // Half of 2^SHIFT, added before the shift to round half up
  localparam int unsigned ROUND  = 8;
  localparam int unsigned SHIFT  = 4;

  // 16 * 255 = 4080 plus rounding (4088) still fits in 12 bits
  localparam int unsigned SUM_W  = 12;

endpackage : grayscale_pkg
`default_nettype wire

// File: rtl/gray_core.sv
`default_nettype none
// ============================================================================
// Module   : gray_core
// Purpose  : Combinational packed RGB {b,g,r} to 8-bit gray conversion.
//            gray = (5r + 9g + 2b + 8) >> 4
// Revision : 1.0 - initial release
// ============================================================================
module gray_core
  import grayscale_pkg::*;
(
  input  logic [23:0] rgb_i,
  output logic [7:0]  gray_o
);

  logic [SUM_W-1:0] w_r;
  logic [SUM_W-1:0] w_g;
  logic [SUM_W-1:0] w_b;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_rounded;
  logic [SUM_W-1:0] w_shifted;

  // Weighted sum with round-half-up; the shifted result never exceeds 255
  always_comb begin
    w_r       = SUM_W'(rgb_i[7:0]);
    w_g       = SUM_W'(rgb_i[15:8]);
    w_b       = SUM_W'(rgb_i[23:16]);
    w_sum     = (w_r * SUM_W'(COEF_R)) + (w_g * SUM_W'(COEF_G)) + (w_b * SUM_W'(COEF_B));
    w_rounded = w_sum + SUM_W'(ROUND);
    w_shifted = w_rounded >> SHIFT;
    gray_o    = w_shifted[7:0];
  end

endmodule : gray_core
`default_nettype wire

// File: rtl/grayscale_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : grayscale_frame_ctrl
// Purpose  : Streams a full frame of RGB pixels from the source memory
//            through gray_core into the destination memory, one pixel per
//            cycle, with a start/busy/done handshake and a read-side hold.
// Revision : 1.0 - initial release
// ============================================================================
module grayscale_frame_ctrl
  import grayscale_pkg::*;
#(
  parameter int unsigned NPIX = 16384,
  parameter int unsigned AW   = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [23:0]   rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;
  logic          last_d;
  logic          busy_q;
  logic          done_q;
  logic          rd_en_q;
  logic [AW-1:0] rd_addr_q;

  // Pipeline: stage 1 marks the cycle read data is on rd_data,
  // stage 2 holds the registered write
  logic          v1_q;
  logic [AW-1:0] a1_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [7:0]    w_gray;

  // Next counter value and last-pixel detect for the read sequencer
  always_comb begin
    cnt_d  = cnt_q + AW'(1);
    last_d = (cnt_q == LAST_ADDR);
  end

  // Frame FSM: read sequencing, counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_en_q <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!hold) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= cnt_q;
            cnt_q     <= cnt_d;
            if (last_d) begin
              state_q <= DRAIN;
            end
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          // Wait until the last read has left stage 1 before signalling done
          rd_en_q <= 1'b0;
          if (!rd_en_q && !v1_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  gray_core u_gray_core (
    .rgb_i  (rd_data),
    .gray_o (w_gray)
  );

  // Read-to-write pipeline; the write side never stalls, hold only gates reads
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      a1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      v1_q    <= rd_en_q;
      a1_q    <= rd_addr_q;
      wr_en_q <= v1_q;
      if (v1_q) begin
        wr_addr_q <= a1_q;
        wr_data_q <= w_gray;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule : grayscale_frame_ctrl
`default_nettype wire

// File: tb/tb_grayscale_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_grayscale_frame_ctrl
// Purpose  : Directed self-checking bench; one 4-pixel and one 1-pixel
//            instance share the control inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grayscale_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hold = 1'b0;

  logic       busy0, done0, rd_en0, wr_en0;
  logic [1:0] rd_addr0, wr_addr0;
  logic [7:0] wr_data0;
  logic [23:0] rd_data0 = '0;

  logic       busy1, done1, rd_en1, wr_en1;
  logic [0:0] rd_addr1, wr_addr1;
  logic [7:0] wr_data1;
  logic [23:0] rd_data1 = '0;

  logic [23:0] mem0 [0:3];
  logic [23:0] mem1;

  // Per-cycle record of DUT outputs (index = cycle number of a frame)
  logic       c_busy0 [0:15];
  logic       c_done0 [0:15];
  logic       c_rd0   [0:15];
  logic [1:0] c_ra0   [0:15];
  logic       c_wr0   [0:15];
  logic [1:0] c_wa0   [0:15];
  logic [7:0] c_wd0   [0:15];
  logic       c_busy1 [0:15];
  logic       c_done1 [0:15];
  logic       c_rd1   [0:15];
  logic       c_wr1   [0:15];
  logic [7:0] c_wd1   [0:15];

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  grayscale_frame_ctrl #(.NPIX(4), .AW(2)) dut0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy0), .done(done0), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0)
  );

  grayscale_frame_ctrl #(.NPIX(1), .AW(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
  );

  // Source memories: data is valid the cycle after rd_en
  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= mem0[rd_addr0];
    if (rd_en1) rd_data1 <= mem1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int c);
    c_busy0[c] = busy0; c_done0[c] = done0; c_rd0[c] = rd_en0; c_ra0[c] = rd_addr0;
    c_wr0[c] = wr_en0;  c_wa0[c] = wr_addr0; c_wd0[c] = wr_data0;
    c_busy1[c] = busy1; c_done1[c] = done1; c_rd1[c] = rd_en1;
    c_wr1[c] = wr_en1;  c_wd1[c] = wr_data1;
  endtask

  // Cycle 0 carries start=1; inputs for cycle c are driven right after sampling it
  task automatic run_frame(input int n, input int hold_lo, input int hold_hi,
                           input int restart_cyc, input int rst_cyc);
    start = 1'b1; hold = 1'b0; rst = 1'b0;
    record(0);
    for (int c = 1; c <= n; c++) begin
      tick();
      record(c);
      start = (c == restart_cyc);
      hold  = (c >= hold_lo) && (c <= hold_hi);
      rst   = (c == rst_cyc);
    end
    start = 1'b0; hold = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nchecks++;
      if ({busy0, done0, rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0} !== 15'd0) begin
        nerrors++;
        $display("FAIL reset_idle cyc=%0d busy=%b done=%b rd_en=%b rd_addr=%0d wr_en=%b wr_addr=%0d wr_data=%0d, required all 0",
                 i, busy0, done0, rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0);
      end
      nchecks++;
      if ({busy1, done1, rd_en1, wr_en1, wr_data1} !== 12'd0) begin
        nerrors++;
        $display("FAIL reset_idle_npix1 cyc=%0d busy=%b done=%b rd_en=%b wr_en=%b, required all 0",
                 i, busy1, done1, rd_en1, wr_en1);
      end
    end
  endtask

  // Nominal NPIX=4 frame; also checks timing of every handshake signal
  task automatic test_basic_timing(input int restart_cyc, input string tag);
    logic [7:0] gexp [0:3];
    int wi;
    mem0[0] = 24'hFFFFFF; mem0[1] = 24'h000000; mem0[2] = 24'h000010; mem0[3] = 24'h000100;
    gexp[0] = 8'd255; gexp[1] = 8'd0; gexp[2] = 8'd5; gexp[3] = 8'd1;
    run_frame(10, -1, -1, restart_cyc, -1);
    for (int c = 1; c <= 10; c++) begin
      nchecks++;
      if (c_rd0[c] !== (c >= 2 && c <= 5) || (c >= 2 && c <= 5 && c_ra0[c] !== 2'(c - 2))) begin
        nerrors++;
        $display("FAIL %s_rd cyc=%0d rd_en=%b rd_addr=%0d, required rd_en=%b addr=%0d",
                 tag, c, c_rd0[c], c_ra0[c], (c >= 2 && c <= 5), c - 2);
      end
      wi = c - 4;
      nchecks++;
      if (c_wr0[c] !== (wi >= 0 && wi <= 3) ||
          (wi >= 0 && wi <= 3 && (c_wa0[c] !== 2'(wi) || c_wd0[c] !== gexp[wi & 3]))) begin
        nerrors++;
        $display("FAIL %s_wr cyc=%0d wr_en=%b wr_addr=%0d wr_data=%0d, required wr_en=%b addr=%0d",
                 tag, c, c_wr0[c], c_wa0[c], c_wd0[c], (wi >= 0 && wi <= 3), wi);
      end
      nchecks++;
      if (c_done0[c] !== (c == 8) || c_busy0[c] !== (c <= 8)) begin
        nerrors++;
        $display("FAIL %s_hs cyc=%0d done=%b busy=%b, required done=%b busy=%b",
                 tag, c, c_done0[c], c_busy0[c], (c == 8), (c <= 8));
      end
    end
  endtask

  task automatic test_pixels();
    logic [7:0] gexp [0:3];
    mem0[0] = 24'h070000; mem0[1] = 24'h000001; mem0[2] = 24'h102030; mem0[3] = 24'h808080;
    gexp[0] = 8'd1; gexp[1] = 8'd0; gexp[2] = 8'd35; gexp[3] = 8'd128;
    run_frame(10, -1, -1, -1, -1);
    for (int k = 0; k < 4; k++) begin
      nchecks++;
      if (c_wr0[k + 4] !== 1'b1 || c_wd0[k + 4] !== gexp[k]) begin
        nerrors++;
        $display("FAIL pixel_%0d wr_en=%b wr_data=%0d, required wr_en=1 wr_data=%0d",
                 k, c_wr0[k + 4], c_wd0[k + 4], gexp[k]);
      end
    end
  endtask

  // Hold sampled at the edges closing cycles 2 and 3 leaves reads idle in 3 and 4
  task automatic test_hold();
    int rc [0:3];
    int hit;
    rc[0] = 2; rc[1] = 5; rc[2] = 6; rc[3] = 7;
    run_frame(12, 2, 3, -1, -1);
    for (int c = 1; c <= 12; c++) begin
      hit = -1;
      for (int k = 0; k < 4; k++) if (rc[k] == c) hit = k;
      nchecks++;
      if (c_rd0[c] !== (hit >= 0) || (hit >= 0 && c_ra0[c] !== 2'(hit))) begin
        nerrors++;
        $display("FAIL hold_rd cyc=%0d rd_en=%b rd_addr=%0d, required rd_en=%b addr=%0d",
                 c, c_rd0[c], c_ra0[c], (hit >= 0), hit);
      end
      hit = -1;
      for (int k = 0; k < 4; k++) if (rc[k] + 2 == c) hit = k;
      nchecks++;
      if (c_wr0[c] !== (hit >= 0) || (hit >= 0 && c_wa0[c] !== 2'(hit))) begin
        nerrors++;
        $display("FAIL hold_wr cyc=%0d wr_en=%b wr_addr=%0d, required wr_en=%b addr=%0d",
                 c, c_wr0[c], c_wa0[c], (hit >= 0), hit);
      end
      nchecks++;
      if (c_done0[c] !== (c == 10) || c_busy0[c] !== (c <= 10)) begin
        nerrors++;
        $display("FAIL hold_hs cyc=%0d done=%b busy=%b, required done=%b busy=%b",
                 c, c_done0[c], c_busy0[c], (c == 10), (c <= 10));
      end
    end
  endtask

  task automatic test_npix1();
    mem1 = 24'h000010;
    run_frame(8, -1, -1, -1, -1);
    for (int c = 1; c <= 8; c++) begin
      nchecks++;
      if (c_rd1[c] !== (c == 2) || c_wr1[c] !== (c == 4) ||
          (c == 4 && c_wd1[c] !== 8'd5)) begin
        nerrors++;
        $display("FAIL npix1_rw cyc=%0d rd_en=%b wr_en=%b wr_data=%0d, required rd_en=%b wr_en=%b data=5",
                 c, c_rd1[c], c_wr1[c], c_wd1[c], (c == 2), (c == 4));
      end
      nchecks++;
      if (c_done1[c] !== (c == 5) || c_busy1[c] !== (c <= 5)) begin
        nerrors++;
        $display("FAIL npix1_hs cyc=%0d done=%b busy=%b, required done=%b busy=%b",
                 c, c_done1[c], c_busy1[c], (c == 5), (c <= 5));
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    run_frame(10, -1, -1, -1, 5);
    nchecks++;
    if ({c_busy0[6], c_done0[6], c_rd0[6], c_ra0[6], c_wr0[6], c_wa0[6], c_wd0[6]} !== 15'd0) begin
      nerrors++;
      $display("FAIL rst_mid_zero busy=%b done=%b rd_en=%b rd_addr=%0d wr_en=%b wr_addr=%0d wr_data=%0d, required all 0",
               c_busy0[6], c_done0[6], c_rd0[6], c_ra0[6], c_wr0[6], c_wa0[6], c_wd0[6]);
    end
    for (int c = 7; c <= 10; c++) begin
      nchecks++;
      if (c_wr0[c] !== 1'b0 || c_rd0[c] !== 1'b0 || c_busy0[c] !== 1'b0) begin
        nerrors++;
        $display("FAIL rst_mid_quiet cyc=%0d wr_en=%b rd_en=%b busy=%b, required 0 0 0",
                 c, c_wr0[c], c_rd0[c], c_busy0[c]);
      end
    end
    test_basic_timing(-1, "after_rst");
  endtask

  initial begin
    mem1 = 24'h000000;
    for (int i = 0; i < 4; i++) mem0[i] = 24'h0;
    test_reset();
    test_basic_timing(-1, "basic");
    test_pixels();
    test_hold();
    test_basic_timing(3, "restart_busy");
    test_npix1();
    test_rst_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_grayscale_frame_ctrl
`default_nettype wire

// File: doc/grayscale_frame_ctrl.md
# grayscale_frame_ctrl

Controller that converts a full frame of packed RGB pixels to 8-bit gray. It issues reads to the source image memory, runs each returned pixel through the weighted-sum grayscale core, and writes results to the destination gray memory at the same address. Software sees a start/busy/done handshake. The block streams one pixel per cycle and stalls on `hold`.

## Interface
- `NPIX`, 16384: pixels per frame, ≥1
- `AW`, 14: address width, 2^AW ≥ NPIX
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  frame request, sampled only in IDLE
- `hold`  in  1  source memory not available; suppresses new reads
- `busy`  out  1  high from the cycle after start is accepted through the done cycle
- `done`  out  1  one-cycle pulse; frame fully written
- `rd_en`  out  1  source read strobe
- `rd_addr`  out  AW  source address
- `rd_data`  in  24  source pixel {b[23:16], g[15:8], r[7:0]}, valid the cycle after `rd_en`
- `wr_en`  out  1  destination write strobe
- `wr_addr`  out  AW  destination address
- `wr_data`  out  8  gray value

## Operation
- Reset: state IDLE; `busy`, `done`, `rd_en`, `wr_en` = 0; `rd_addr`, `wr_addr`, `wr_data`, pixel counter = 0.
- All outputs are registered. `busy` = (state != IDLE). `done` = (state == DONE).
- States:
  - IDLE: when start=1, clear cnt and go to RUN.
  - RUN: at each edge with hold=0, set rd_en<=1, rd_addr<=cnt, cnt<=cnt+1. If cnt==NPIX-1 on that edge, go to DRAIN. At each edge with hold=1, set rd_en<=0; cnt and state are unchanged.
  - DRAIN: set rd_en<=0. When rd_en==0 and v1==0, go to DONE.
  - DONE: lasts one cycle, then IDLE.
- Pipeline stage 1: v1<=rd_en; a1<=rd_addr.
- Pipeline stage 2: wr_en<=v1. When v1=1, wr_addr<=a1 and wr_data<=gray(rd_data). When v1=0, wr_addr and wr_data hold their values.
- Arithmetic:
  - sum = 5r + 9g + 2b, 12 bits unsigned (max 4080).
  - gray = (sum + 8) >> 4, which rounds half up. Result max 255 and needs no saturation.
- Boundary behaviour:
  - `start` while busy: ignored.
  - `hold` only gates new reads. An in-flight read always completes and is written, so the write side never stalls.
  - `hold` in DRAIN or DONE: no effect.
  - NPIX=1: the single read transitions directly from RUN to DRAIN.
  - `rst` mid-frame: immediate return to reset values; in-flight writes are dropped, and the next start restarts at address 0.
  - Address does not wrap: the last read address is NPIX-1.

## Timing
- Cycle 0: start=1 in IDLE. Cycle 1: state RUN, busy=1.
- With hold=0 throughout:
  - rd_en high cycles 2..NPIX+1, addresses 0..NPIX-1.
  - wr_en high cycles 4..NPIX+3.
  - done pulse cycle NPIX+4; busy=0 from cycle NPIX+5.
- Read-to-write latency: 2 cycles (rd_en cycle k → wr_en cycle k+2, same address).
- Each cycle with hold=1 in RUN adds exactly one cycle to the frame and leaves a one-cycle gap in the write stream.
- Throughput: 1 pixel/cycle.

## Structure
- Package `grayscale_pkg`:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - coefficient constants R=5, G=9, B=2.
  - rounding constant 8; shift 4; sum width 12.
- Sub-module `gray_core`: combinational 24-bit RGB → 8-bit gray using the rule above, instantiated once between `rd_data` and the stage-2 register.
- The controller owns the FSM, counter and pipeline registers.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, busy=0. NPIX=4, start pulse at cycle 0 → rd_en cycles 2–5 with addresses 0–3, wr_en cycles 4–7, done only at cycle 8, busy=0 at cycle 9.
- Pixel values:
  - 24'hFFFFFF → 255.
  - 24'h000000 → 0.
  - 24'h000010 (r=16) → 5.
  - 24'h000100 (g=1) → 1 (9+8=17>>4).
  - 24'h070000 (b=7) → 1 (14+8=22>>4).
  - 24'h000001 (r=1) → 0.
- hold=1 for cycles 3–4 with NPIX=4 → addresses 0,(gap),(gap),1,2,3; writes in order with 2 gaps; done at cycle 10.
- start re-pulsed at cycle 3 while busy → no effect on address sequence or done timing. NPIX=1 → a single read/write, done at cycle 5.
- rst asserted at cycle 5 of an NPIX=4 frame → all outputs 0 at cycle 6 and no further writes. A new start then reads from address 0 and completes a full frame.
